// File: rtl/reset_sequencer.sv
// Staged reset sequencer.
// Asserts every per-domain active-low reset asynchronously while the external
// reset is high or the PLL is unlocked. Releases them synchronously: first the
// synchroniser, then a hold time, then one output per gap. A software request
// restarts the hold/release sequence without touching the synchroniser.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUTPUTS = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   lock,
  input  logic                   sw_reset,
  output logic [NUM_OUTPUTS-1:0] reset_n_out,
  output logic                   ready
);

  localparam int MAXC = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUTPUTS - 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  logic                   clr;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_go;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_OUTPUTS-1:0] out_q, out_d;
  logic                   rdy_q, rdy_d;

  // Clear is asserted by external reset or by loss of PLL lock.
  assign clr = reset | ~lock;

  // The FSM leaves ASSERT on the very edge the last synchroniser stage rises,
  // so the launch condition is taken from the stage feeding it.
  assign sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
  assign sync_go = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];

  // Synchroniser shift chain, cleared asynchronously.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  // FSM, counters and registered outputs, cleared asynchronously.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      rdy_q   <= rdy_d;
    end
  end

  // Next-state logic: hold timing, staged release, soft-reset override.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    out_d   = out_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      ST_ASSERT: begin
        out_d = '0;
        rdy_d = 1'b0;
        if (sync_go) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          out_d[0] = 1'b1;
          cnt_d    = '0;
          idx_d    = IW'(1);
          if (NUM_OUTPUTS == 1) begin
            state_d = ST_RUN;
            rdy_d   = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          out_d = out_q | (NUM_OUTPUTS'(1) << idx_q);
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
            rdy_d   = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        out_d = '1;
        rdy_d = 1'b1;
      end
      default: state_d = ST_ASSERT;
    endcase
    // Soft reset wins over any sequencing step once the synchroniser is done.
    if (sw_reset && (state_q != ST_ASSERT)) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      out_d   = '0;
      rdy_d   = 1'b0;
    end
  end

  assign reset_n_out = out_q;
  assign ready       = rdy_q;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset sequencer for the video controller. It asserts a vector of per-domain active-low resets asynchronously whenever the external reset is high or the PLL loses lock. It releases them synchronously and in order: first a configurable synchroniser depth, then a hold time, then a fixed gap between successive outputs. It sits between the clock generator/PLL and the video pipeline blocks. It replaces the fixed 3-flop reset chain with staged release and a software-requested reset.

## Interface
- SYNC_STAGES, 2: synchroniser depth for clear deassertion; legal range ≥ 2.
- NUM_OUTPUTS, 3: number of staged reset outputs; legal range 1..16.
- HOLD_CYCLES, 16: cycles between synchroniser release (or soft reset) and release of output 0; legal range ≥ 1.
- STAGE_GAP, 4: cycles between release of output i and output i+1; legal range ≥ 1.

Ports:
- clock  input  1  system clock; all state is clocked on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- lock  input  1  PLL lock, asynchronous; low is treated exactly like reset high.
- sw_reset  input  1  synchronous soft-reset request, sampled each rising edge.
- reset_n_out  output  NUM_OUTPUTS  per-domain active-low resets; index 0 is released first.
- ready  output  1  high only when every reset_n_out bit is high.

## Operation
- Internal clear is active when reset is high or lock is low.
- While clear is active, all flops are forced asynchronously: reset_n_out = 0, ready = 0, synchroniser = 0, state = ASSERT, counters = 0.
- Assertion is immediate and does not need a clock edge.
- Synchroniser: a SYNC_STAGES-deep shift chain fed with 1 and cleared by clear. Its last stage enables the FSM.
- FSM states:
  - ASSERT: all outputs low. Move to HOLD with cnt = 0 on the edge where the synchroniser's last stage becomes 1.
  - HOLD: cnt increments each edge. When HOLD_CYCLES cycles have elapsed in HOLD, release reset_n_out[0], set idx = 1 and cnt = 0, then go to RELEASE. If NUM_OUTPUTS = 1, go directly to RUN instead.
  - RELEASE: cnt increments each edge. When STAGE_GAP cycles have elapsed, release reset_n_out[idx] and clear cnt. Go to RUN once the last index is released, otherwise increment idx.
  - RUN: all outputs high, ready = 1.
- Released outputs stay high; bits are never re-asserted individually.
- sw_reset = 1 sampled in HOLD, RELEASE or RUN:
  - On that edge, drive all reset_n_out low and ready low.
  - Enter HOLD with cnt = 0, which restarts the full hold and release sequence.
- sw_reset is ignored in ASSERT.
- A held-high sw_reset keeps the block in HOLD with cnt = 0.
- Counter width is clog2(max(HOLD_CYCLES, STAGE_GAP) + 1); counters never wrap within a state.
- ready is registered and changes on the same edge as the last reset_n_out bit.

## Timing
- Edge 1 is the first rising edge at which clear is inactive; power-up is the same as any clear removal.
- Synchroniser last stage is high after edge SYNC_STAGES.
- FSM is in HOLD from edge SYNC_STAGES.
- reset_n_out[i] rises on edge SYNC_STAGES + HOLD_CYCLES + i·STAGE_GAP.
- ready rises on edge SYNC_STAGES + HOLD_CYCLES + (NUM_OUTPUTS−1)·STAGE_GAP.
- Defaults give: out0 at edge 18, out1 at edge 22, out2 at edge 26, ready at edge 26.
- sw_reset sampled high at edge k:
  - all outputs low after edge k;
  - reset_n_out[i] rises at edge k + HOLD_CYCLES + i·STAGE_GAP, assuming sw_reset is low after edge k.
- Clear asserted at any time, including mid-HOLD, mid-RELEASE, or together with sw_reset: all outputs go low asynchronously within combinational delay, and the sequence restarts from edge 1 rules once clear is removed.
- Clear glitches shorter than one clock period must still force full assertion and a complete restart.

## Test plan
- Power-up, defaults: reset=1 for 5 cycles with lock=1, then reset=0 -> reset_n_out bits rise at edges 18, 22 and 26; ready rises at edge 26; no earlier transitions.
- Lock loss during RELEASE: drop lock for 2 ns at edge 20 (out0 already high) -> reset_n_out goes 3'b000 with no clock edge; sequence repeats with out0 at edge 18 relative to lock return.
- sw_reset pulse in RUN: one-cycle pulse at edge 40 -> outputs low after edge 40; out0 at 56, out1 at 60, out2 at 64; ready at 64.
- sw_reset held for 10 cycles, edges 40–49 -> out0 rises at edge 65 (HOLD restarted at every edge of the pulse); sw_reset asserted in ASSERT has no effect.
- Parameter sweep: SYNC_STAGES=3, NUM_OUTPUTS=1, HOLD_CYCLES=1, STAGE_GAP=1 -> out0 and ready rise at edge 4.
- Also run NUM_OUTPUTS=16, STAGE_GAP=2 -> bit i rises at edge 18 + 2i; ready at edge 48; release order strictly monotonic.
